// File: rtl/rr_arbiter8_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | rr_arbiter8_pkg : shared types and constants for the arbiter slice |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
package rr_arbiter8_pkg;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_e;

   localparam int NUM_REQ = 8;
   localparam int IDX_W   = 3;

endpackage : rr_arbiter8_pkg
`default_nettype wire

// File: rtl/rr_arbiter8_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | rr_arbiter8_if : request/grant bundle between requesters & arbiter |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
interface rr_arbiter8_if;
   import rr_arbiter8_pkg::*;

   logic               en;
   logic [NUM_REQ-1:0] req;
   logic [NUM_REQ-1:0] gnt;
   logic [IDX_W-1:0]   gnt_idx;
   logic               gnt_valid;
   logic               hold_expired;

   modport master (
      output en, req,
      input  gnt, gnt_idx, gnt_valid, hold_expired
   );

   modport slave (
      input  en, req,
      output gnt, gnt_idx, gnt_valid, hold_expired
   );

endinterface : rr_arbiter8_if
`default_nettype wire

// File: rtl/rr_arbiter8_decoder3x8.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | decoder3x8 : 3-to-8 one-hot decoder with enable                    |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
module decoder3x8 (
   input  wire logic       en,
   input  wire logic [2:0] sel,
   output logic      [7:0] y
);

   always_comb begin
      y = 8'h00;
      if (en) begin
         y[sel] = 1'b1;
      end
   end

endmodule : decoder3x8
`default_nettype wire

// File: rtl/rr_arbiter8.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | rr_arbiter8 : 8-way round-robin arbiter with grant hold timeout    |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
module rr_arbiter8
   import rr_arbiter8_pkg::*;
#(
   parameter int MAX_HOLD = 16,
   parameter int CNT_W    = $clog2(MAX_HOLD)
) (
   input wire logic     clk,
   input wire logic     rst,
   rr_arbiter8_if.slave bus
);

   localparam logic [0:0]       c_st_idle   = 1'(IDLE);
   localparam logic [0:0]       c_st_grant  = 1'(GRANT);
   localparam logic [CNT_W-1:0] c_hold_last = CNT_W'(MAX_HOLD - 1);

   logic [0:0]         r_state;
   logic [IDX_W-1:0]   r_gnt_idx;
   logic [IDX_W-1:0]   r_last_idx;
   logic               r_gnt_valid;
   logic               r_hold_expired;
   logic [CNT_W-1:0]   r_hold_cnt;

   logic [IDX_W-1:0]   w_pick;
   logic               w_others;
   logic               w_cnt_bad;

   // Scan from last+1 upward with wrap; descending loop lets the nearest bit win.
   function automatic logic [IDX_W-1:0] pick(input logic [NUM_REQ-1:0] r,
                                             input logic [IDX_W-1:0]   last);
      logic [IDX_W-1:0] idx;
      pick = last;
      for (int k = NUM_REQ; k >= 1; k--) begin
         idx = last + IDX_W'(k);
         if (r[idx]) begin
            pick = idx;
         end
      end
   endfunction

   assign w_pick    = pick(bus.req, r_last_idx);
   assign w_others  = |(bus.req & ~(NUM_REQ'(1) << r_gnt_idx));
   assign w_cnt_bad = (int'(r_hold_cnt) >= MAX_HOLD);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state        <= c_st_idle;
         r_gnt_idx      <= '0;
         r_last_idx     <= IDX_W'(NUM_REQ - 1);
         r_gnt_valid    <= 1'b0;
         r_hold_expired <= 1'b0;
         r_hold_cnt     <= '0;
      end else begin
         r_hold_expired <= 1'b0;
         case (r_state)
            c_st_idle: begin
               if (bus.en && (|bus.req)) begin
                  r_state     <= c_st_grant;
                  r_gnt_valid <= 1'b1;
                  r_gnt_idx   <= w_pick;
                  r_last_idx  <= w_pick;
                  r_hold_cnt  <= '0;
               end
            end
            c_st_grant: begin
               if (!bus.en || w_cnt_bad) begin
                  r_state     <= c_st_idle;
                  r_gnt_valid <= 1'b0;
               end else if (!bus.req[r_gnt_idx]) begin
                  // Holder released: hand over in the same edge if anyone waits.
                  if (|bus.req) begin
                     r_gnt_idx  <= w_pick;
                     r_last_idx <= w_pick;
                     r_hold_cnt <= '0;
                  end else begin
                     r_state     <= c_st_idle;
                     r_gnt_valid <= 1'b0;
                  end
               end else if (r_hold_cnt == c_hold_last) begin
                  r_hold_cnt <= '0;
                  if (w_others) begin
                     r_gnt_idx      <= w_pick;
                     r_last_idx     <= w_pick;
                     r_hold_expired <= 1'b1;
                  end
               end else begin
                  r_hold_cnt <= r_hold_cnt + 1'b1;
               end
            end
            default: begin
               r_state     <= c_st_idle;
               r_gnt_valid <= 1'b0;
               r_hold_cnt  <= '0;
            end
         endcase
      end
   end

   assign bus.gnt_idx      = r_gnt_idx;
   assign bus.gnt_valid    = r_gnt_valid;
   assign bus.hold_expired = r_hold_expired;

   decoder3x8 u_decoder (
      .en  (r_gnt_valid),
      .sel (r_gnt_idx),
      .y   (bus.gnt)
   );

endmodule : rr_arbiter8
`default_nettype wire
